// File: rtl/sc_datamem_bytelane_if.sv
// ---------------------------------------------------------------------------
// sc_datamem_bytelane_if
// Request/response bus between the CPU load/store unit (master) and the
// byte-lane data memory (slave).
//   req        : access request, taken only while ready=1
//   we         : 1 = store, 0 = load
//   addr       : byte address
//   size       : 00 byte, 01 halfword, 10 word, 11 illegal
//   uns        : loads only, 1 = zero-extend, 0 = sign-extend
//   wdata      : store data, right-justified for byte/halfword
//   ready      : memory can take a request this cycle
//   resp_valid : one-cycle response pulse
//   rdata      : load result, meaningful while resp_valid=1
//   err        : response error flag, meaningful while resp_valid=1
// ---------------------------------------------------------------------------
interface sc_datamem_bytelane_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        ready;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, size, uns, wdata,
        input  ready, resp_valid, rdata, err
    );

    modport slave (
        input  req, we, addr, size, uns, wdata,
        output ready, resp_valid, rdata, err
    );
endinterface

// File: rtl/sc_datamem_bytelane.sv
// ---------------------------------------------------------------------------
// sc_datamem_bytelane
// Word-organised data memory with byte/halfword/word loads and stores,
// a request/response handshake with WAIT_STATES extra cycles, and detection
// of misaligned or out-of-range accesses.
//   clock  : single clock, rising edge
//   resetn : asynchronous active-low reset (array contents are not reset)
//   bus    : slave side of sc_datamem_bytelane_if
//
// state  | meaning
// IDLE   | ready for a request, no response pending
// WAIT   | request latched, burning wait states
// ACCESS | array read / byte-lane write happens on the closing edge
// RESP   | resp_valid high; a new request may be accepted here
// ---------------------------------------------------------------------------
module sc_datamem_bytelane #(
    parameter int          ADDR_WIDTH  = 5,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                         clock,
    input  logic                         resetn,
    sc_datamem_bytelane_if.slave         bus
);
    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam int         WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] WS_INIT = 4'(WS_M1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           word;
    logic [31:0]           load_data;
    logic [31:0]           store_word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic                  req_err;
    logic                  mem_we;

    assign idx  = addr_q[ADDR_WIDTH+1:2];
    assign word = mem[idx];

    // Upper-bit mismatch is always an error so out-of-range never aliases.
    always_comb begin
        case (size_q)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = addr_q[0];
            2'b10:   req_err = (addr_q[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (addr_q[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        byte_sel  = word[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = addr_q[1] ? word[31:16] : word[15:0];
        load_data = 32'h0;
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            2'b10:   load_data = word;
            default: load_data = 32'h0;
        endcase
    end

    // Read-modify-write of the whole word keeps untouched lanes intact.
    always_comb begin
        store_word = word;
        case (size_q)
            2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    assign mem_we = (state_q == ST_ACCESS) && we_q && !req_err;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx] <= store_word;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (ready_q && bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    size_d  = bus.size;
                    uns_d   = bus.uns;
                    wdata_d = bus.wdata;
                    ready_d = 1'b0;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_WAIT: begin
                ready_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                state_d      = ST_RESP;
                ready_d      = 1'b1;
                resp_valid_d = 1'b1;
                err_d        = req_err;
                rdata_d      = (we_q || req_err) ? 32'h0 : load_data;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= 32'h0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.rdata      = rdata_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_sc_datamem_bytelane.sv
module tb_sc_datamem_bytelane;
    logic clock  = 1'b0;
    logic resetn = 1'b1;

    always #5 clock = ~clock;

    sc_datamem_bytelane_if if0 ();
    sc_datamem_bytelane_if if3 ();

    sc_datamem_bytelane #(.ADDR_WIDTH(5), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (if0.slave)
    );

    sc_datamem_bytelane #(.ADDR_WIDTH(5), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut3 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (if3.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input int d, input logic rq, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        if (d == 0) begin
            if0.req = rq; if0.we = we; if0.addr = addr; if0.size = size; if0.uns = uns; if0.wdata = wdata;
        end else begin
            if3.req = rq; if3.we = we; if3.addr = addr; if3.size = size; if3.uns = uns; if3.wdata = wdata;
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? if0.ready : if3.ready;
    endfunction

    function automatic logic get_rv(input int d);
        return (d == 0) ? if0.resp_valid : if3.resp_valid;
    endfunction

    task automatic push(input int d, input logic [31:0] rdata, input logic err, input string name);
        exp_t e;
        e.rdata = rdata; e.err = err; e.name = name;
        if (d == 0) q0.push_back(e);
        else        q3.push_back(e);
    endtask

    // Scoreboard monitors: pop one expectation per response pulse.
    always @(negedge clock) begin
        exp_t e;
        if (resetn && if0.resp_valid) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut0 unexpected response: actual=resp_valid required=none");
            end else begin
                e = q0.pop_front();
                check({"dut0 ", e.name, " rdata"}, if0.rdata, e.rdata);
                check({"dut0 ", e.name, " err"}, {31'b0, if0.err}, {31'b0, e.err});
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (resetn && if3.resp_valid) begin
            if (q3.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut3 unexpected response: actual=resp_valid required=none");
            end else begin
                e = q3.pop_front();
                check({"dut3 ", e.name, " rdata"}, if3.rdata, e.rdata);
                check({"dut3 ", e.name, " err"}, {31'b0, if3.err}, {31'b0, e.err});
            end
        end
    end

    task automatic wait_ready(input int d, input string name);
        int n = 0;
        while (!get_ready(d) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL %s ready timeout: actual=0 required=1", name);
        end
    endtask

    // Counts edges after accept until resp_valid and ready-low cycles in between.
    task automatic wait_resp(input int d, input string name);
        int n   = 0;
        int low = 0;
        int ws  = (d == 0) ? 0 : 3;
        while (!get_rv(d) && n < 50) begin
            if (!get_ready(d)) low++;
            @(negedge clock);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(1 + ws));
        check({name, " busy cycles"}, 32'(low), 32'(1 + ws));
    endtask

    task automatic do_req(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input string name);
        @(negedge clock);
        wait_ready(d, name);
        drive(d, 1'b1, we, addr, size, uns, wdata);
        push(d, exp_rdata, exp_err, name);
        @(posedge clock);
        @(negedge clock);
        // Garbage while busy must not disturb the latched request.
        drive(d, 1'b0, ~we, ~addr, 2'b11, ~uns, ~wdata);
        wait_resp(d, name);
    endtask

    task automatic b2b(input int d,
                       input logic we1, input logic [31:0] a1, input logic [31:0] w1, input logic [31:0] e1,
                       input logic we2, input logic [31:0] a2, input logic [31:0] w2, input logic [31:0] e2);
        @(negedge clock);
        wait_ready(d, "b2b first");
        drive(d, 1'b1, we1, a1, 2'b10, 1'b0, w1);
        push(d, e1, 1'b0, "b2b first");
        @(posedge clock);
        @(negedge clock);
        drive(d, 1'b1, we2, a2, 2'b10, 1'b0, w2);
        push(d, e2, 1'b0, "b2b second");
        wait_resp(d, "b2b first");
        check("b2b ready in RESP", {31'b0, get_ready(d)}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        drive(d, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        wait_resp(d, "b2b second");
    endtask

    initial begin
        int seen;
        drive(0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        drive(3, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("reset ready",      {31'b0, if0.ready},      32'd1);
        check("reset resp_valid", {31'b0, if0.resp_valid}, 32'd0);
        check("reset rdata",      if0.rdata,               32'h0);
        check("reset err",        {31'b0, if0.err},        32'd0);
        resetn = 1'b1;

        // ---- zero wait states ----
        do_req(0, 1, 32'h08, 2'b10, 0, 32'hDEADBEEF, 32'h0,        0, "st word 08");
        do_req(0, 0, 32'h08, 2'b10, 0, 32'h0,        32'hDEADBEEF, 0, "ld word 08");
        repeat (3) @(negedge clock);
        check("rdata hold", if0.rdata, 32'hDEADBEEF);

        do_req(0, 1, 32'h08, 2'b10, 0, 32'h11223344, 32'h0,        0, "st word 08b");
        do_req(0, 1, 32'h0B, 2'b00, 0, 32'hAAAAAA80, 32'h0,        0, "st byte 0B");
        do_req(0, 0, 32'h08, 2'b10, 1, 32'h0,        32'h80223344, 0, "ld word after byte");
        do_req(0, 0, 32'h0B, 2'b00, 0, 32'h0,        32'hFFFFFF80, 0, "ld byte 0B sx");
        do_req(0, 0, 32'h0B, 2'b00, 1, 32'h0,        32'h00000080, 0, "ld byte 0B zx");
        do_req(0, 0, 32'h08, 2'b00, 0, 32'h0,        32'h00000044, 0, "ld byte 08 sx");
        do_req(0, 0, 32'h0A, 2'b00, 0, 32'h0,        32'h00000022, 0, "ld byte 0A sx");

        do_req(0, 1, 32'h0C, 2'b10, 0, 32'h12345678, 32'h0,        0, "st word 0C");
        do_req(0, 1, 32'h0E, 2'b01, 0, 32'h5A5AA5A5, 32'h0,        0, "st half 0E");
        do_req(0, 0, 32'h0E, 2'b01, 0, 32'h0,        32'hFFFFA5A5, 0, "ld half 0E sx");
        do_req(0, 0, 32'h0E, 2'b01, 1, 32'h0,        32'h0000A5A5, 0, "ld half 0E zx");
        do_req(0, 0, 32'h0C, 2'b10, 0, 32'h0,        32'hA5A55678, 0, "ld word 0C");
        do_req(0, 0, 32'h0C, 2'b01, 0, 32'h0,        32'h00005678, 0, "ld half 0C sx");
        do_req(0, 0, 32'h0D, 2'b00, 0, 32'h0,        32'h00000056, 0, "ld byte 0D sx");

        do_req(0, 1, 32'h04, 2'b10, 0, 32'hCAFEF00D, 32'h0,        0, "st word 04");
        do_req(0, 1, 32'h06, 2'b10, 0, 32'hDEADDEAD, 32'h0,        1, "st word 06 misaligned");
        do_req(0, 0, 32'h04, 2'b10, 0, 32'h0,        32'hCAFEF00D, 0, "ld word 04 unchanged");
        do_req(0, 0, 32'h80, 2'b10, 0, 32'h0,        32'h0,        1, "ld word 80 range");
        do_req(0, 0, 32'h00, 2'b11, 0, 32'h0,        32'h0,        1, "ld size 11");
        do_req(0, 0, 32'h09, 2'b01, 0, 32'h0,        32'h0,        1, "ld half 09 misaligned");
        do_req(0, 0, 32'h0E, 2'b10, 0, 32'h0,        32'h0,        1, "ld word 0E misaligned");
        do_req(0, 1, 32'h10000008, 2'b00, 0, 32'h000000FF, 32'h0,  1, "st byte upper bits");
        do_req(0, 0, 32'h08, 2'b10, 0, 32'h0,        32'h80223344, 0, "ld word 08 no alias");

        // ---- three wait states ----
        do_req(3, 1, 32'h10, 2'b10, 0, 32'h0BADF00D, 32'h0,        0, "ws3 st word 10");
        do_req(3, 0, 32'h10, 2'b10, 0, 32'h0,        32'h0BADF00D, 0, "ws3 ld word 10");
        b2b(3, 1'b1, 32'h14, 32'h55AA55AA, 32'h0, 1'b0, 32'h14, 32'h0, 32'h55AA55AA);

        // ---- reset during WAIT of a store ----
        @(negedge clock);
        wait_ready(3, "rst store");
        drive(3, 1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'hFFFF0000);
        @(posedge clock);
        @(negedge clock);
        drive(3, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        @(negedge clock);
        check("mid-wait busy", {31'b0, if3.ready}, 32'd0);
        resetn = 1'b0;
        #1;
        check("mid-reset ready",      {31'b0, if3.ready},      32'd1);
        check("mid-reset resp_valid", {31'b0, if3.resp_valid}, 32'd0);
        check("mid-reset rdata",      if3.rdata,               32'h0);
        check("mid-reset err",        {31'b0, if3.err},        32'd0);
        @(negedge clock);
        resetn = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (if3.resp_valid) seen++;
        end
        check("no resp after reset", 32'(seen), 32'd0);
        do_req(3, 0, 32'h10, 2'b10, 0, 32'h0, 32'h0BADF00D, 0, "ws3 ld 10 after reset");

        repeat (3) @(negedge clock);
        check("scoreboard drained", 32'(q0.size() + q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
